mc_sequencer: RTL
=================

Name: mc_sequencer

Overview:
Multi-cycle control FSM for the MIPS core. It sequences the shared datapath (PC, IR, register file, ALU, unified memory port) through the fetch, decode, execute, memory and writeback steps of each instruction, holding memory accesses until the memory's handshake completes. It replaces single-cycle control when the core runs against a unified, variable-latency memory. It also halts on syscall and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  opcode from external IR; valid from DECODE onward
funct  in  6  funct from external IR; valid from DECODE onward
zero  in  1  ALU zero flag, sampled in BRANCH
mem_ready  in  1  memory completes the current request this cycle
resume  in  1  leave HALT; ignored in all other states
pc_we  out  1  PC write enable
pc_src  out  2  00 pc+4, 01 branch target, 10 jump target, 11 rs register
ir_we  out  1  IR write enable
mem_req  out  1  memory request; held until mem_ready
mem_we  out  1  memory write; valid only with mem_req
iord  out  1  memory address: 0 PC, 1 ALU result
reg_we  out  1  register file write enable
reg_dst  out  2  00 rt, 01 rd, 10 r31
wb_src  out  2  00 ALU, 01 memory data, 10 link (PC)
alu_src_b  out  2  00 rt, 01 sign-extended imm, 10 zero-extended imm
shift  out  1  shamt shift
shift_var  out  1  variable shift (rs amount)
usign  out  1  unsigned add (no overflow)
aluop  out  4  ALU operation code
halted  out  1  high in HALT
illegal  out  1  one-cycle pulse on unsupported op/funct
retired  out  CNT_W  completed-instruction count

Behaviour:
- Reset: state IDLE; retired = 0. All outputs are 0 during reset and in IDLE. IDLE always moves to FETCH on the next edge.
- Outputs are Moore-decoded from the state plus the op/funct inputs. Every enable not listed for a state is 0.
- aluop encodings: SLL 0000, SRA 0001, SRL 0010, ADD 0101, SUB 0110, AND 0111, OR 1000, NOR 1010, SLT 1011, SLTU 1100.
- FETCH:
  - Outputs: mem_req=1, iord=0.
  - On mem_ready: ir_we=1, pc_we=1 with pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH with the request held.
- DECODE: no enables asserted. Next state by instruction class:
  - R-type ALU (add, addu, sub, and, or, nor, slt, sltu, sll, srl, sra, sllv, srav) and I-type ALU (addi, addiu, andi, ori, slti) go to EXEC.
  - lw and sw go to ADDR.
  - beq and bne go to BRANCH.
  - j, jal and jr go to JUMP.
  - syscall goes to HALT and increments retired.
  - Anything else pulses illegal, goes to FETCH and does not increment retired.
- EXEC: drive aluop, alu_src_b, shift, shift_var and usign per instruction, then go to ALU_WB.
  - andi and ori use alu_src_b=10.
  - Other I-type instructions use alu_src_b=01.
- ALU_WB: hold the EXEC ALU controls and assert reg_we=1, with reg_dst=01 for R-type and 00 for I-type, and wb_src=00. Then go to FETCH and increment retired.
- ADDR: aluop=ADD, alu_src_b=01. Go to MEM.
- MEM: mem_req=1, iord=1, mem_we=1 for sw; hold aluop and alu_src_b.
  - On mem_ready, lw goes to LOAD_WB; sw goes to FETCH and increments retired.
- LOAD_WB: reg_we=1, reg_dst=00, wb_src=01. Go to FETCH and increment retired.
- BRANCH: aluop=SUB, alu_src_b=00. pc_we=1 with pc_src=01 when beq and zero=1, or bne and zero=0. Go to FETCH and increment retired.
- JUMP: pc_we=1. Go to FETCH and increment retired.
  - j: pc_src=10.
  - jal: pc_src=10, plus reg_we=1, reg_dst=10, wb_src=10.
  - jr: pc_src=11.
- HALT: halted=1. resume=1 moves to FETCH on the next edge.
- Timing and boundary rules:
  - mem_ready is ignored while mem_req=0.
  - A zero-wait memory (mem_ready in the first request cycle) completes that access in one cycle.
  - Zero-wait latencies: R/I ALU 4 cycles, lw 5, sw 4, branch 3, j/jal/jr 3.
  - retired saturates at all-ones.
  - rst_n asserted mid-request drops mem_req asynchronously and abandons the instruction, with no PC or register write.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, DECODE, EXEC, ALU_WB, ADDR, MEM, LOAD_WB, BRANCH, JUMP, HALT);
  - opcode and funct constants;
  - aluop constants;
  - pc_src, reg_dst, wb_src and alu_src_b encodings.
- One combinational sub-module, mc_decode, maps op/funct to instruction class, aluop, alu_src_b, shift, shift_var and usign. The FSM instantiates it.

Test Plan:
- add ($rd=op 000000, funct 100000), mem_ready held 1: FETCH, DECODE, EXEC, ALU_WB. reg_we=1, reg_dst=01, aluop=0101 in ALU_WB; retired 0 to 1.
- lw (op 100011), mem_ready 0 for 3 cycles in MEM: mem_req=1, iord=1 held for 4 cycles, then LOAD_WB with reg_we=1, wb_src=01.
- beq (op 000100) with zero=1 gives pc_we=1, pc_src=01 in BRANCH. bne (op 000101) with zero=1 gives pc_we=0 in BRANCH.
- jal (op 000011): JUMP with pc_src=10, reg_we=1, reg_dst=10, wb_src=10 in the same cycle.
- syscall (funct 001100): halted=1 stays high for 10 cycles with resume=0. A resume pulse returns the FSM to FETCH with mem_req=1.
- op 111111: illegal pulses for 1 cycle, next state FETCH, retired unchanged. rst_n low mid-FETCH wait: mem_req drops to 0 immediately.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, instruction
// classes, opcode/funct values and datapath mux selects.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      IDLE, FETCH, DECODE, EXEC, ALU_WB, ADDR, MEM, LOAD_WB, BRANCH, JUMP, HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE,
      CLS_BRANCH, CLS_JUMP, CLS_SYSCALL, CLS_ILLEGAL
   } iclass_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL     = 6'b000000;
   localparam logic [5:0] FN_SRL     = 6'b000010;
   localparam logic [5:0] FN_SRA     = 6'b000011;
   localparam logic [5:0] FN_SLLV    = 6'b000100;
   localparam logic [5:0] FN_SRAV    = 6'b000111;
   localparam logic [5:0] FN_JR      = 6'b001000;
   localparam logic [5:0] FN_SYSCALL = 6'b001100;
   localparam logic [5:0] FN_ADD     = 6'b100000;
   localparam logic [5:0] FN_ADDU    = 6'b100001;
   localparam logic [5:0] FN_SUB     = 6'b100010;
   localparam logic [5:0] FN_AND     = 6'b100100;
   localparam logic [5:0] FN_OR      = 6'b100101;
   localparam logic [5:0] FN_NOR     = 6'b100111;
   localparam logic [5:0] FN_SLT     = 6'b101010;
   localparam logic [5:0] FN_SLTU    = 6'b101011;

   localparam logic [3:0] ALU_SLL  = 4'b0000;
   localparam logic [3:0] ALU_SRA  = 4'b0001;
   localparam logic [3:0] ALU_SRL  = 4'b0010;
   localparam logic [3:0] ALU_ADD  = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_NOR  = 4'b1010;
   localparam logic [3:0] ALU_SLT  = 4'b1011;
   localparam logic [3:0] ALU_SLTU = 4'b1100;

   localparam logic [1:0] PC_SRC_PC4    = 2'b00;
   localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
   localparam logic [1:0] PC_SRC_RS     = 2'b11;

   localparam logic [1:0] REG_DST_RT  = 2'b00;
   localparam logic [1:0] REG_DST_RD  = 2'b01;
   localparam logic [1:0] REG_DST_R31 = 2'b10;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_MEM  = 2'b01;
   localparam logic [1:0] WB_LINK = 2'b10;

   localparam logic [1:0] SRCB_RT   = 2'b00;
   localparam logic [1:0] SRCB_SIMM = 2'b01;
   localparam logic [1:0] SRCB_ZIMM = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decode: op/funct to instruction class plus the
// ALU controls used by EXEC/ALU_WB.
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output logic [2:0] cls,
   output logic [3:0] aluop,
   output logic [1:0] alu_src_b,
   output logic       shift,
   output logic       shift_var,
   output logic       usign
);

   always_comb begin
      cls       = CLS_ILLEGAL;
      aluop     = ALU_SLL;
      alu_src_b = SRCB_RT;
      shift     = 1'b0;
      shift_var = 1'b0;
      usign     = 1'b0;
      case (op)
         OP_RTYPE: begin
            cls = CLS_ALU_R;
            case (funct)
               FN_ADD:     aluop = ALU_ADD;
               FN_ADDU:    begin aluop = ALU_ADD; usign = 1'b1; end
               FN_SUB:     aluop = ALU_SUB;
               FN_AND:     aluop = ALU_AND;
               FN_OR:      aluop = ALU_OR;
               FN_NOR:     aluop = ALU_NOR;
               FN_SLT:     aluop = ALU_SLT;
               FN_SLTU:    aluop = ALU_SLTU;
               FN_SLL:     begin aluop = ALU_SLL; shift = 1'b1; end
               FN_SRL:     begin aluop = ALU_SRL; shift = 1'b1; end
               FN_SRA:     begin aluop = ALU_SRA; shift = 1'b1; end
               FN_SLLV:    begin aluop = ALU_SLL; shift_var = 1'b1; end
               FN_SRAV:    begin aluop = ALU_SRA; shift_var = 1'b1; end
               FN_JR:      cls = CLS_JUMP;
               FN_SYSCALL: cls = CLS_SYSCALL;
               default:    cls = CLS_ILLEGAL;
            endcase
         end
         OP_ADDI:  begin cls = CLS_ALU_I; aluop = ALU_ADD; alu_src_b = SRCB_SIMM; end
         OP_ADDIU: begin cls = CLS_ALU_I; aluop = ALU_ADD; alu_src_b = SRCB_SIMM; usign = 1'b1; end
         OP_SLTI:  begin cls = CLS_ALU_I; aluop = ALU_SLT; alu_src_b = SRCB_SIMM; end
         // Logical immediates are zero-extended.
         OP_ANDI:  begin cls = CLS_ALU_I; aluop = ALU_AND; alu_src_b = SRCB_ZIMM; end
         OP_ORI:   begin cls = CLS_ALU_I; aluop = ALU_OR;  alu_src_b = SRCB_ZIMM; end
         OP_LW:    cls = CLS_LOAD;
         OP_SW:    cls = CLS_STORE;
         OP_BEQ, OP_BNE:      cls = CLS_BRANCH;
         OP_J, OP_JAL:        cls = CLS_JUMP;
         default:  cls = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM sequencing the shared MIPS datapath against a
// variable-latency unified memory; halts on syscall, counts retirements.
//
// state   | meaning
// IDLE    | post-reset, all controls low
// FETCH   | instruction read at PC, IR/PC loaded on mem_ready
// DECODE  | classify instruction, flag illegal
// EXEC    | ALU operation for R/I-type
// ALU_WB  | write ALU result to rd/rt
// ADDR    | effective address for lw/sw
// MEM     | data access at ALU address until mem_ready
// LOAD_WB | write load data to rt
// BRANCH  | compare rs/rt, conditional PC update
// JUMP    | j/jal/jr PC update (jal also links r31)
// HALT    | stopped after syscall until resume
module mc_sequencer
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       op,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   input  logic             resume,
   output logic             pc_we,
   output logic [1:0]       pc_src,
   output logic             ir_we,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic [1:0]       wb_src,
   output logic [1:0]       alu_src_b,
   output logic             shift,
   output logic             shift_var,
   output logic             usign,
   output logic [3:0]       aluop,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   state_t     state;
   logic [2:0] cls;
   logic [3:0] dec_aluop;
   logic [1:0] dec_src_b;
   logic       dec_shift, dec_shift_var, dec_usign;
   logic       retire;

   mc_decode u_decode (
      .op        (op),
      .funct     (funct),
      .cls       (cls),
      .aluop     (dec_aluop),
      .alu_src_b (dec_src_b),
      .shift     (dec_shift),
      .shift_var (dec_shift_var),
      .usign     (dec_usign)
   );

   always_comb begin
      retire = 1'b0;
      case (state)
         ALU_WB, LOAD_WB, BRANCH, JUMP: retire = 1'b1;
         DECODE: retire = (cls == CLS_SYSCALL);
         MEM:    retire = mem_ready && (cls == CLS_STORE);
         default: retire = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         retired <= '0;
      end else begin
         if (retire && (retired != '1))
            retired <= retired + CNT_W'(1);
         case (state)
            IDLE:    state <= FETCH;
            FETCH:   if (mem_ready) state <= DECODE;
            DECODE: begin
               case (cls)
                  CLS_ALU_R, CLS_ALU_I:  state <= EXEC;
                  CLS_LOAD, CLS_STORE:   state <= ADDR;
                  CLS_BRANCH:            state <= BRANCH;
                  CLS_JUMP:              state <= JUMP;
                  CLS_SYSCALL:           state <= HALT;
                  default:               state <= FETCH;
               endcase
            end
            EXEC:    state <= ALU_WB;
            ADDR:    state <= MEM;
            MEM:     if (mem_ready) state <= (cls == CLS_LOAD) ? LOAD_WB : FETCH;
            ALU_WB, LOAD_WB, BRANCH, JUMP: state <= FETCH;
            HALT:    if (resume) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end

   // Decoded from state (async reset) so mem_req drops the moment rst_n falls.
   always_comb begin
      pc_we = 1'b0; pc_src = PC_SRC_PC4; ir_we = 1'b0;
      mem_req = 1'b0; mem_we = 1'b0; iord = 1'b0;
      reg_we = 1'b0; reg_dst = REG_DST_RT; wb_src = WB_ALU;
      alu_src_b = SRCB_RT; shift = 1'b0; shift_var = 1'b0; usign = 1'b0;
      aluop = ALU_SLL; halted = 1'b0; illegal = 1'b0;
      case (state)
         FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we = 1'b1;
               pc_we = 1'b1;
            end
         end
         DECODE: illegal = (cls == CLS_ILLEGAL);
         EXEC, ALU_WB: begin
            aluop     = dec_aluop;
            alu_src_b = dec_src_b;
            shift     = dec_shift;
            shift_var = dec_shift_var;
            usign     = dec_usign;
            if (state == ALU_WB) begin
               reg_we  = 1'b1;
               reg_dst = (cls == CLS_ALU_R) ? REG_DST_RD : REG_DST_RT;
            end
         end
         ADDR, MEM: begin
            aluop     = ALU_ADD;
            alu_src_b = SRCB_SIMM;
            if (state == MEM) begin
               mem_req = 1'b1;
               iord    = 1'b1;
               mem_we  = (cls == CLS_STORE);
            end
         end
         LOAD_WB: begin
            reg_we = 1'b1;
            wb_src = WB_MEM;
         end
         BRANCH: begin
            aluop = ALU_SUB;
            if (((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero)) begin
               pc_we  = 1'b1;
               pc_src = PC_SRC_BRANCH;
            end
         end
         JUMP: begin
            pc_we = 1'b1;
            if (op == OP_J) begin
               pc_src = PC_SRC_JUMP;
            end else if (op == OP_JAL) begin
               pc_src  = PC_SRC_JUMP;
               reg_we  = 1'b1;
               reg_dst = REG_DST_R31;
               wb_src  = WB_LINK;
            end else begin
               pc_src = PC_SRC_RS;
            end
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

endmodule
